jamma_input_conditioner: RTL and testbench

- Conditions the raw JAMMA edge-connector inputs and produces the clean P[28:0] bus that the IDE/JAMMA interface block samples.
- Per-bit functions: two-flop synchroniser, then a tick-based debouncer.
- Coin functions: catches every coin insertion on the two coin lines into saturating event counters. A host acknowledge strobe clears those counters, so short coin pulses are never missed between polls.
- Sits between the connector pins and the interface block's P input.

---
 rtl/jamma_input_conditioner_if.sv | 28 ++
 rtl/jamma_input_conditioner.sv | 128 ++++++++++++
 tb/tb_jamma_input_conditioner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/jamma_input_conditioner_if.sv
// Connector-side bundle between the raw JAMMA pins, the conditioner and the
// host that polls the coin counters.
interface jamma_input_conditioner_if;
  logic [28:0] Praw;
  logic [28:0] P;
  logic        coinAck;
  logic [3:0]  coinCntA;
  logic [3:0]  coinCntB;
  logic        change;

  modport master (
    output Praw,
    output coinAck,
    input  P,
    input  coinCntA,
    input  coinCntB,
    input  change
  );

  modport slave (
    input  Praw,
    input  coinAck,
    output P,
    output coinCntA,
    output coinCntB,
    output change
  );
endinterface

// File: rtl/jamma_input_conditioner.sv
// Synchronises and debounces the 29 JAMMA inputs, and latches coin insertions
// into saturating counters that the host clears with coinAck.
module jamma_input_conditioner #(
  parameter int   PRESCALE    = 1000,
  parameter int   DEB_TICKS   = 4,
  parameter int   COIN_A_BIT  = 20,
  parameter int   COIN_B_BIT  = 21,
  parameter logic COIN_ACTIVE = 1'b0
) (
  input  logic                       clk,
  input  logic                       nReset,
  jamma_input_conditioner_if.slave   bus
);

  localparam int          W    = 29;
  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);
  localparam logic [2:0]  DMAX = 3'(DEB_TICKS - 1);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] w_p;
  logic [W-1:0] r_p_prev;
  logic [15:0]  r_presc;
  logic         w_tick;
  logic [3:0]   r_cnt_a;
  logic [3:0]   r_cnt_b;
  logic         r_change;
  logic         w_evt_a;
  logic         w_evt_b;
  logic         w_diff;

  // Idle level is all ones so a reset never looks like a pressed input.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= bus.Praw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_presc <= '0;
    end else if (r_presc == PMAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  assign w_tick = (r_presc == PMAX);

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_deb
      logic [2:0] r_cnt;
      logic       r_bit;

      // Progress only advances on ticks; any agreement clears it at once.
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          r_cnt <= '0;
          r_bit <= 1'b1;
        end else if (r_s2[gi] == r_bit) begin
          r_cnt <= '0;
        end else if (w_tick) begin
          if (r_cnt == DMAX) begin
            r_bit <= r_s2[gi];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
      end

      assign w_p[gi] = r_bit;
    end
  endgenerate

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_p_prev <= '1;
    end else begin
      r_p_prev <= w_p;
    end
  end

  assign w_evt_a = (w_p[COIN_A_BIT] == COIN_ACTIVE) && (r_p_prev[COIN_A_BIT] != COIN_ACTIVE);
  assign w_evt_b = (w_p[COIN_B_BIT] == COIN_ACTIVE) && (r_p_prev[COIN_B_BIT] != COIN_ACTIVE);
  assign w_diff  = |(w_p ^ r_p_prev);

  // An event coinciding with the acknowledge survives as a count of one.
  function automatic logic [3:0] coin_next(input logic [3:0] cnt,
                                           input logic       evt,
                                           input logic       ack);
    logic [3:0] nxt;
    nxt = cnt;
    if (ack) begin
      nxt = evt ? 4'd1 : 4'd0;
    end else if (evt && (cnt != 4'd15)) begin
      nxt = cnt + 4'd1;
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_change <= 1'b0;
    end else begin
      r_cnt_a <= coin_next(r_cnt_a, w_evt_a, bus.coinAck);
      r_cnt_b <= coin_next(r_cnt_b, w_evt_b, bus.coinAck);
      if (w_diff) begin
        r_change <= 1'b1;
      end else if (bus.coinAck) begin
        r_change <= 1'b0;
      end
    end
  end

  assign bus.P        = w_p;
  assign bus.coinCntA = r_cnt_a;
  assign bus.coinCntB = r_cnt_b;
  assign bus.change   = r_change;

endmodule

// File: tb/tb_jamma_input_conditioner.sv
// Directed bench for jamma_input_conditioner with PRESCALE=4, DEB_TICKS=3;
// expected values are worked out by hand from the debounce timing.
module tb_jamma_input_conditioner;

  localparam logic [28:0] ONES = 29'h1FFFFFFF;

  logic clk    = 1'b0;
  logic nReset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  jamma_input_conditioner_if bus ();

  jamma_input_conditioner #(
    .PRESCALE   (4),
    .DEB_TICKS  (3),
    .COIN_A_BIT (20),
    .COIN_B_BIT (21),
    .COIN_ACTIVE(1'b0)
  ) dut (
    .clk   (clk),
    .nReset(nReset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[tb] %s got=%0h exp=%0h ok", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    bus.coinAck = 1'b1;
    step();
    bus.coinAck = 1'b0;
  endtask

  // Returns the number of clocks until P[idx] reaches val, or 0 on timeout.
  task automatic wait_p(input int idx, input logic val, input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (bus.P[idx] === val) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic coin_pulse(input int idx);
    bus.Praw[idx] = 1'b0;
    repeat (20) step();
    bus.Praw[idx] = 1'b1;
    repeat (20) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    bus.Praw    = ONES;
    bus.coinAck = 1'b0;
    nReset      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_P", bus.P, ONES);
    check("rst_cntA", bus.coinCntA, 0);
    check("rst_cntB", bus.coinCntB, 0);
    check("rst_change", bus.change, 0);

    nReset = 1'b1;
    bad = 0;
    repeat (100) begin
      step();
      if (bus.P !== ONES || bus.coinCntA !== 4'd0 || bus.coinCntB !== 4'd0 || bus.change !== 1'b0)
        bad++;
    end
    check("idle_bad_cycles", bad, 0);

    // Clean falling edge on bit 3.
    bus.Praw[3] = 1'b0;
    wait_p(3, 1'b0, 20, n);
    check("p3_latency_in_11_14", (n >= 11 && n <= 14), 1);
    check("p3_change_not_yet", bus.change, 0);
    check("p3_other_bits", bus.P, 29'h1FFFFFF7);
    step();
    check("p3_change_set", bus.change, 1);
    ack_pulse();
    check("ack_clears_change", bus.change, 0);

    // Six-clock glitch on bit 5 must be rejected.
    bus.Praw[5] = 1'b0;
    repeat (6) step();
    bus.Praw[5] = 1'b1;
    bad = 0;
    repeat (30) begin
      step();
      if (bus.P[5] !== 1'b1 || bus.change !== 1'b0) bad++;
    end
    check("glitch_bad_cycles", bad, 0);
    // A leftover count would shorten this to a single tick.
    bus.Praw[5] = 1'b0;
    wait_p(5, 1'b0, 20, n);
    check("p5_full_latency_after_glitch", (n >= 11 && n <= 14), 1);
    bus.Praw[5] = 1'b1;
    wait_p(5, 1'b1, 20, n);
    check("p5_return_high", (n >= 11 && n <= 14), 1);
    ack_pulse();

    // Coin A counting and saturation.
    repeat (3) coin_pulse(20);
    check("coinA_three", bus.coinCntA, 3);
    check("coinB_idle", bus.coinCntB, 0);
    repeat (16) coin_pulse(20);
    check("coinA_saturated", bus.coinCntA, 15);
    ack_pulse();
    check("coinA_acked", bus.coinCntA, 0);
    check("change_acked", bus.change, 0);

    // Acknowledge lands in the same clock as a Coin B event.
    bus.Praw[21] = 1'b0;
    wait_p(21, 1'b0, 20, n);
    check("coinB_latency", (n >= 11 && n <= 14), 1);
    bus.coinAck = 1'b1;
    step();
    bus.coinAck = 1'b0;
    check("coinB_event_with_ack", bus.coinCntB, 1);
    check("change_kept_with_ack", bus.change, 1);
    step();
    check("coinB_no_double_count", bus.coinCntB, 1);
    bus.Praw[21] = 1'b1;
    wait_p(21, 1'b1, 20, n);

    // Reset in the middle of a bit-10 debounce (count already at two).
    bus.Praw[10] = 1'b0;
    repeat (10) step();
    nReset = 1'b0;
    #1;
    check("async_rst_P", bus.P, ONES);
    check("async_rst_cntB", bus.coinCntB, 0);
    check("async_rst_change", bus.change, 0);
    @(posedge clk);
    #1;
    nReset = 1'b1;
    wait_p(10, 1'b0, 30, n);
    check("p10_latency_after_reset", n, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
